alu_arbiter_2ch: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit, 3-bit-opcode ALU. Each requester presents an opcode and two 8-bit operands on a valid/ready handshake. The block grants one request per cycle round-robin and drives the ALU. It registers the result with requester ID and zero flag in a one-entry output stage with its own valid/ready handshake. It sits between the two datapath users and the single ALU instance.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 32 +++
 rtl/alu_arbiter_2ch.sv | 118 +++++++++++
 tb/tb_alu_arbiter_2ch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-channel ALU arbiter: data width,
// opcode encoding and a small zero-detect helper.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_OR   = 3'b000,
    OP_AND  = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOT  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_INCA = 3'b110,
    OP_INCB = 3'b111
  } alu_op_t;

  // True when every bit of the ALU result is clear.
  function automatic logic is_zero(input logic [DATA_W-1:0] value);
    return value == '0;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU. Arithmetic results are truncated to
// DATA_W bits, so add, subtract and the increments all wrap modulo 256.
import alu_pkg::*;

module alu_core (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s
);

  alu_op_t op_dec;

  assign op_dec = alu_op_t'(op);

  // Opcode decode; every encoding is defined, the default only guards X.
  always_comb begin
    s = '0;
    unique case (op_dec)
      OP_OR:   s = a | b;
      OP_AND:  s = a & b;
      OP_XOR:  s = a ^ b;
      OP_NOT:  s = ~a;
      OP_ADD:  s = a + b;
      OP_SUB:  s = a - b;
      OP_INCA: s = a + DATA_W'(1);
      OP_INCB: s = b + DATA_W'(1);
      default: s = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_2ch.sv
// Round-robin arbiter in front of one shared ALU. Two requesters hand in
// (op, a, b) on valid/ready; the winner's operands go straight through the
// ALU and the answer lands in a one-entry result register that has its own
// valid/ready handshake. Per-requester counters tally consumed results.
import alu_pkg::*;

module alu_arbiter_2ch (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2:0]        req0_op,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  output logic              res_zero,
  output logic [7:0]        busy_cnt0,
  output logic [7:0]        busy_cnt1
);

  logic              last_grant;
  logic [1:0]        grant;
  logic              free;
  logic              transfer;
  logic              consume;
  logic              sel;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_s;

  // Grant the lone valid requester, or on contention the one that did not win last.
  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // The result slot can take a new entry when empty or being drained this cycle.
  // req_ready is forced low while reset is held so nothing looks accepted.
  always_comb begin
    free      = !res_valid || res_ready;
    req_ready = rst ? 2'b00 : (grant & {2{free}});
    transfer  = |(req_valid & req_ready);
    consume   = res_valid && res_ready;
    sel       = grant[1];
  end

  // Steer the granted requester's operation into the single ALU.
  always_comb begin
    alu_op = req0_op;
    alu_a  = req0_a;
    alu_b  = req0_b;
    if (sel) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  alu_core u_alu_core (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .s  (alu_s)
  );

  // One-entry result register: load on accept, otherwise empty when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_zero  <= 1'b0;
    end else if (transfer) begin
      res_valid <= 1'b1;
      res_data  <= alu_s;
      res_id    <= sel;
      res_zero  <= is_zero(alu_s);
    end else if (consume) begin
      res_valid <= 1'b0;
    end
  end

  // Remember who won last; reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (transfer) begin
      last_grant <= sel;
    end
  end

  // Count consumed results against the requester that produced them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt0 <= 8'd0;
      busy_cnt1 <= 8'd0;
    end else if (consume) begin
      if (res_id) begin
        busy_cnt1 <= busy_cnt1 + 8'd1;
      end else begin
        busy_cnt0 <= busy_cnt0 + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter_2ch.sv
// Self-checking bench for alu_arbiter_2ch. Directed operations are queued
// per requester and their hand-computed results are pushed, in the order
// the arbiter must deliver them, into a scoreboard that a monitor drains.
module tb_alu_arbiter_2ch;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_id;
  logic       res_zero;
  logic [7:0] busy_cnt0, busy_cnt1;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       zero;
  } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_2ch dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_op   (req0_op),
    .req1_op   (req1_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_zero  (res_zero),
    .busy_cnt0 (busy_cnt0),
    .busy_cnt1 (busy_cnt1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Queue an operation on one requester and record the result it must produce.
  task automatic applyStimulus(input logic id, input alu_op_t op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] exp_data);
    op_t  o;
    exp_t e;
    o.op = op;
    o.a  = a;
    o.b  = b;
    if (id) q1.push_back(o);
    else    q0.push_back(o);
    e.id   = id;
    e.data = exp_data;
    e.zero = (exp_data == 8'h00);
    sb.push_back(e);
  endtask

  task automatic present_heads();
    req_valid = {q1.size() > 0, q0.size() > 0};
    if (q0.size() > 0) begin
      req0_op = q0[0].op;
      req0_a  = q0[0].a;
      req0_b  = q0[0].b;
    end
    if (q1.size() > 0) begin
      req1_op = q1[0].op;
      req1_a  = q1[0].a;
      req1_b  = q1[0].b;
    end
  endtask

  // Requester model: handshake seen at the negedge retires the head after the edge.
  task automatic drive_loop();
    logic [1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (acc[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc[1] && q1.size() > 0) void'(q1.pop_front());
      present_heads();
    end
  endtask

  // Every result the consumer takes must match the next scoreboard entry.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got id=%0d data=%0h, expected none",
                   res_id, res_data);
        end else begin
          e = sb.pop_front();
          checkOutput("result{id,data,zero}", 32'({res_id, res_data, res_zero}), 32'(e));
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && !res_valid) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s_timeout: res_valid=0, expected 1", name);
  endtask

  initial begin
    rst       = 1'b1;
    res_ready = 1'b0;
    req_valid = 2'b00;
    req0_op   = 3'd0;
    req1_op   = 3'd0;
    req0_a    = 8'h00;
    req0_b    = 8'h00;
    req1_a    = 8'h00;
    req1_b    = 8'h00;
    fork
      drive_loop();
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'h00);
    checkOutput("rst_res_id", 32'(res_id), 32'd0);
    checkOutput("rst_res_zero", 32'(res_zero), 32'd0);
    checkOutput("rst_busy_cnt0", 32'(busy_cnt0), 32'd0);
    checkOutput("rst_busy_cnt1", 32'(busy_cnt1), 32'd0);

    // First op from requester 0: 0F + 01 = 10
    applyStimulus(1'b0, OP_ADD, 8'h0F, 8'h01, 8'h10);
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready_held", 32'(req_ready), 32'b00);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("first_req_ready", 32'(req_ready), 32'b01);
    @(negedge clk);
    @(negedge clk);
    checkOutput("first_busy_cnt0", 32'(busy_cnt0), 32'd1);
    wait_idle("first");

    // Requester 1 alone: zero result, then additive wrap
    @(posedge clk);
    #2;
    applyStimulus(1'b1, OP_SUB, 8'h05, 8'h05, 8'h00);
    applyStimulus(1'b1, OP_ADD, 8'hFF, 8'h02, 8'h01);
    wait_idle("req1_only");
    checkOutput("req1_busy_cnt1", 32'(busy_cnt1), 32'd2);
    checkOutput("req1_busy_cnt0", 32'(busy_cnt0), 32'd1);

    // Continuous contention: must alternate 0,1,0,1,0,1
    @(posedge clk);
    #2;
    applyStimulus(1'b0, OP_OR,   8'h12, 8'h21, 8'h33);
    applyStimulus(1'b1, OP_INCA, 8'h7F, 8'h00, 8'h80);
    applyStimulus(1'b0, OP_AND,  8'hF0, 8'h3C, 8'h30);
    applyStimulus(1'b1, OP_INCB, 8'h00, 8'hFF, 8'h00);
    applyStimulus(1'b0, OP_XOR,  8'hFF, 8'h0F, 8'hF0);
    applyStimulus(1'b1, OP_NOT,  8'h00, 8'h00, 8'hFF);
    wait_idle("alternate");
    checkOutput("alt_busy_cnt0", 32'(busy_cnt0), 32'd4);
    checkOutput("alt_busy_cnt1", 32'(busy_cnt1), 32'd5);

    // Output stall with both requesters waiting
    @(posedge clk);
    #2;
    res_ready = 1'b0;
    applyStimulus(1'b0, OP_ADD, 8'h01, 8'h02, 8'h03);
    applyStimulus(1'b1, OP_SUB, 8'h10, 8'h01, 8'h0F);
    applyStimulus(1'b0, OP_XOR, 8'hAA, 8'hAA, 8'h00);
    applyStimulus(1'b1, OP_OR,  8'h00, 8'h00, 8'h00);
    wait_valid("stall_fill");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall_req_ready", 32'(req_ready), 32'b00);
      checkOutput("stall_res_data", 32'(res_data), 32'h03);
      checkOutput("stall_busy_cnt0", 32'(busy_cnt0), 32'd4);
    end
    @(posedge clk);
    #2 res_ready = 1'b1;
    wait_idle("stall_release");
    checkOutput("stall_busy_cnt0_after", 32'(busy_cnt0), 32'd6);
    checkOutput("stall_busy_cnt1_after", 32'(busy_cnt1), 32'd7);

    // Opcode sweep, a=A5 b=3C
    @(posedge clk);
    #2;
    applyStimulus(1'b0, OP_OR,   8'hA5, 8'h3C, 8'hBD);
    applyStimulus(1'b0, OP_AND,  8'hA5, 8'h3C, 8'h24);
    applyStimulus(1'b0, OP_XOR,  8'hA5, 8'h3C, 8'h99);
    applyStimulus(1'b0, OP_NOT,  8'hA5, 8'h3C, 8'h5A);
    applyStimulus(1'b0, OP_ADD,  8'hA5, 8'h3C, 8'hE1);
    applyStimulus(1'b0, OP_SUB,  8'hA5, 8'h3C, 8'h69);
    applyStimulus(1'b0, OP_INCA, 8'hA5, 8'h3C, 8'hA6);
    applyStimulus(1'b0, OP_INCB, 8'hA5, 8'h3C, 8'h3D);
    wait_idle("sweep");
    checkOutput("sweep_busy_cnt0", 32'(busy_cnt0), 32'd14);

    // Asynchronous reset while a result is pending
    @(posedge clk);
    #2;
    res_ready = 1'b0;
    applyStimulus(1'b0, OP_AND, 8'hFF, 8'h0F, 8'h0F);
    wait_valid("pending_fill");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("arst_res_data", 32'(res_data), 32'h00);
    checkOutput("arst_busy_cnt0", 32'(busy_cnt0), 32'd0);
    checkOutput("arst_busy_cnt1", 32'(busy_cnt1), 32'd0);
    sb.delete();
    applyStimulus(1'b0, OP_INCA, 8'h41, 8'h00, 8'h42);
    applyStimulus(1'b1, OP_INCB, 8'h00, 8'h09, 8'h0A);
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("arst_first_grant", 32'(req_ready), 32'b01);
    wait_idle("after_reset");
    checkOutput("arst_busy_cnt0_after", 32'(busy_cnt0), 32'd1);
    checkOutput("arst_busy_cnt1_after", 32'(busy_cnt1), 32'd1);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
